// File: rtl/rf_wb_scheduler_pkg.sv
// Shared constants for the register-file write-back scheduler.
// Register bank geometry and fixed requester slot assignments.
package rf_wb_scheduler_pkg;

  localparam int REG_AW   = 4;
  localparam int REG_DW   = 32;
  localparam int NUM_REGS = 16;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_HOST = 2;

  // One-hot decode of a register address into a full-bank mask.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] addr);
    logic [NUM_REGS-1:0] oh;
    oh       = '0;
    oh[addr] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rf_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, pointer advances past each winner.
module rr_arbiter #(
  parameter int NREQ = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [1:0]      gnt_idx_o,
  output logic            gnt_valid_o
);

  localparam int PW = (NREQ > 2) ? 2 : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Search from the pointer upward, wrapping, and take the first requester found.
  always_comb begin
    int  idx;
    logic found;
    gnt_o       = '0;
    gnt_idx_o   = 2'd0;
    gnt_valid_o = 1'b0;
    ptr_d       = ptr_q;
    found       = 1'b0;
    idx         = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      if (!found && req_i[idx]) begin
        found       = 1'b1;
        gnt_valid_o = 1'b1;
        gnt_o[idx]  = 1'b1;
        gnt_idx_o   = 2'(idx);
        ptr_d       = (idx == NREQ - 1) ? '0 : PW'(idx + 1);
      end else begin
        found = found;
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Write-back scheduler: arbitrates NREQ producers onto the bank write port, tracks pending writes.
// Optional macro RF_WB_BYPASS_EN adds a two-port forwarding compare on the registered write.
module rf_wb_scheduler
  import rf_wb_scheduler_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = REG_AW,
  parameter int DW   = REG_DW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*AW-1:0]  req_addr,
  input  logic [NREQ*DW-1:0]  req_data,
  input  logic                alloc_valid,
  input  logic [AW-1:0]       alloc_addr,
  output logic [NUM_REGS-1:0] busy_mask,
`ifdef RF_WB_BYPASS_EN
  input  logic [AW-1:0]       byp_addr_a,
  input  logic [AW-1:0]       byp_addr_b,
  output logic                byp_hit_a,
  output logic                byp_hit_b,
  output logic [DW-1:0]       byp_data,
`endif
  output logic                rf_reg_write,
  output logic [AW-1:0]       rf_rd_addr,
  output logic [DW-1:0]       rf_write_data,
  output logic [1:0]          grant_id,
  output logic                err_double_alloc
);

  logic [NREQ-1:0]     gnt_s;
  logic [1:0]          gnt_idx_s;
  logic                xfer_s;
  logic [AW-1:0]       sel_addr_s;
  logic [DW-1:0]       sel_data_s;

  logic                rf_reg_write_q;
  logic [AW-1:0]       rf_rd_addr_q;
  logic [DW-1:0]       rf_write_data_q;
  logic [1:0]          grant_id_q;

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] clr_s;
  logic [NUM_REGS-1:0] set_s;
  logic                err_q;
  logic                err_d;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_valid),
    .gnt_o       (gnt_s),
    .gnt_idx_o   (gnt_idx_s),
    .gnt_valid_o (xfer_s)
  );

  assign req_ready = gnt_s;

  // AND-OR mux of the granted slice; the grant is one-hot so at most one term is live.
  always_comb begin
    sel_addr_s = '0;
    sel_data_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_addr_s = sel_addr_s | ({AW{gnt_s[i]}} & req_addr[i*AW +: AW]);
      sel_data_s = sel_data_s | ({DW{gnt_s[i]}} & req_data[i*DW +: DW]);
    end
  end

  // Bank write stage; r0 transfers are accepted but never raise the write enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_reg_write_q  <= 1'b0;
      rf_rd_addr_q    <= '0;
      rf_write_data_q <= '0;
      grant_id_q      <= 2'd0;
    end else begin
      rf_reg_write_q <= xfer_s && (sel_addr_s != '0);
      if (xfer_s) begin
        rf_rd_addr_q    <= sel_addr_s;
        rf_write_data_q <= sel_data_s;
        grant_id_q      <= gnt_idx_s;
      end else begin
        rf_rd_addr_q    <= rf_rd_addr_q;
        rf_write_data_q <= rf_write_data_q;
        grant_id_q      <= grant_id_q;
      end
    end
  end

  // Scoreboard next state: commit clears, alloc sets and wins a same-edge collision.
  always_comb begin
    clr_s = '0;
    set_s = '0;
    if (rf_reg_write_q) begin
      clr_s = reg_onehot(REG_AW'(rf_rd_addr_q));
    end else begin
      clr_s = '0;
    end
    if (alloc_valid) begin
      set_s = reg_onehot(REG_AW'(alloc_addr));
    end else begin
      set_s = '0;
    end
    busy_d    = (busy_q & ~clr_s) | set_s;
    busy_d[0] = 1'b0;
    if (alloc_valid && (alloc_addr != '0) && busy_q[alloc_addr] && !clr_s[alloc_addr]) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Scoreboard and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign busy_mask        = busy_q;
  assign err_double_alloc = err_q;
  assign rf_reg_write     = rf_reg_write_q;
  assign rf_rd_addr       = rf_rd_addr_q;
  assign rf_write_data    = rf_write_data_q;
  assign grant_id         = grant_id_q;

`ifdef RF_WB_BYPASS_EN
  // Forward the in-flight write to readers that would otherwise see stale bank data.
  assign byp_hit_a = rf_reg_write_q && (rf_rd_addr_q == byp_addr_a) && (byp_addr_a != '0);
  assign byp_hit_b = rf_reg_write_q && (rf_rd_addr_q == byp_addr_b) && (byp_addr_b != '0);
  assign byp_data  = rf_write_data_q;
`endif

endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
- Write-back scheduler for the 16 x 32-bit register bank.
- Shares the bank's single write port between NREQ producers: ALU, load unit, and host/debug loader.
- Arbitrates round-robin and keeps a per-register pending-write scoreboard that issue logic uses for RAW stalls.
- Drives the bank's rd_addr/write_data/reg_write through one registered output stage.

Parameters:
- NREQ, 3, number of write-back requesters (2..4)
- AW, 4, register address width (16 registers)
- DW, 32, data width

Ports:
- clk  in  1  system clock, posedge
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  NREQ  requester i has a write pending
- req_ready  out  NREQ  requester i granted this cycle; combinational from req_valid and RR pointer
- req_addr  in  NREQ*AW  destination register, slice i
- req_data  in  NREQ*DW  write data, slice i
- alloc_valid  in  1  issue stage reserves a destination register
- alloc_addr  in  AW  register being reserved
- busy_mask  out  16  bit r set while a write to r is outstanding
- rf_reg_write  out  1  write enable to register bank
- rf_rd_addr  out  AW  write address to register bank
- rf_write_data  out  DW  write data to register bank
- grant_id  out  2  index of requester that produced the current rf_* write
- err_double_alloc  out  1  sticky: alloc hit an already-busy register

Behaviour:
- Reset values: req_ready=0, busy_mask=0, rf_reg_write=0, rf_rd_addr=0, rf_write_data=0, grant_id=0, err_double_alloc=0, RR pointer=0.
- Handshake:
  - Transfer occurs on req_valid[i] & req_ready[i].
  - Once valid, a requester holds valid/addr/data stable until ready.
  - Dropping valid before ready is a protocol violation; the block ignores it, no error flag.
- Arbitration:
  - At most one grant per cycle.
  - Grant goes to the first valid index at or after the RR pointer, wrapping modulo NREQ.
  - On a grant, the pointer moves to grant+1 mod NREQ; with no grant it holds.
  - Only a single requester valid: granted every cycle (full throughput).
- Latency:
  - A transfer in cycle t drives rf_reg_write=1, rf_rd_addr, rf_write_data and grant_id in cycle t+1.
  - With no transfer in cycle t, rf_reg_write=0 in t+1; addr and data hold their last values.
- r0 handling:
  - A write to address 0 is accepted (ready asserted) but produces rf_reg_write=0 in t+1.
  - busy_mask[0] is hardwired 0.
- Scoreboard:
  - alloc_valid with addr r (r!=0) sets busy_mask[r] on the next edge.
  - A commit (registered rf_reg_write=1 to r) clears busy_mask[r] on the same edge that the bank writes.
  - Same-edge alloc and clear to the same r: set wins; bit stays 1 (new producer).
  - Alloc to r while busy_mask[r]=1 and no clear that edge: set err_double_alloc (sticky until reset); bit stays 1.
  - A write to a non-busy register is legal (host loader path); clearing an already-clear bit is a no-op.
- Reset mid-operation:
  - Any accepted but not-yet-committed write is dropped.
  - Scoreboard, RR pointer and error flag are cleared.
  - rf_reg_write is forced 0 asynchronously.

Optional Feature:
- Macro RF_WB_BYPASS_EN adds inputs byp_addr_a/byp_addr_b (AW) and outputs byp_hit_a/byp_hit_b (1) and byp_data (DW).
- byp_hit_x = rf_reg_write & (rf_rd_addr==byp_addr_x) & (byp_addr_x!=0), combinational.
- byp_data = rf_write_data.
- Purpose: forwarding around the bank's negedge read.
- Without the macro these ports do not exist and the core is unchanged.

Decomposition:
- Shared package holds:
  - REG_AW=4, REG_DW=32, NUM_REGS=16
  - requester index constants REQ_ALU=0, REQ_LOAD=1, REQ_HOST=2
- One sub-module, rr_arbiter: parameterised NREQ, with req vector in, one-hot grant out and pointer register.
- The scoreboard and output register stay in the top level.

Test Plan:
- Reset, then only ALU valid, addr 5, data 0xDEADBEEF:
  - ready[0]=1 in cycle 0.
  - Next cycle: rf_reg_write=1, rf_rd_addr=5, rf_write_data=0xDEADBEEF, grant_id=0.
- All three requesters valid continuously, addrs 1/2/3:
  - Grants go 0,1,2,0,1,2.
  - rf_rd_addr sequence is 1,2,3,1,2,3 with no idle cycles.
- Alloc r9, then LOAD writes r9 three cycles later:
  - busy_mask[9] is 1 from the edge after alloc.
  - It clears on the commit edge.
- Alloc r4 on the same edge that r4 commits:
  - busy_mask[4] stays 1.
  - Then a second alloc r4 with no commit sets err_double_alloc=1 and it holds.
- HOST writes r0 with data 0x1234: ready=1, next cycle rf_reg_write=0, busy_mask[0]=0.
- Assert rst_n=0 mid-cycle after a transfer to r7 and alloc r7:
  - rf_reg_write drops immediately.
  - busy_mask=0; after release, first grant goes to index 0.
